// File: rtl/status_register.sv
// -----------------------------------------------------------------------------
// status_register
//
// Processor status register (P) for a 6502-style core. Holds the six real
// flags N, V, D, I, Z, C as flops. Bit 5 reads as a constant 1. B is never
// stored: it only appears in push_byte, where brk_push supplies it.
// irq_mask is a separate copy of I that is refreshed only at instruction
// boundaries, which gives CLI/SEI/PLP their one-instruction latency for
// interrupt polling.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   alu_n/v/z/c   current-cycle ALU flag results
//   update_nz     N and Z capture alu_n and alu_z
//   update_c      C captures alu_c
//   update_v      V captures alu_v
//   bit_op        BIT semantics: N/V from bus_in[7:6], Z from alu_z
//   load_bus      PLP/RTI: load all flags from bus_in
//   bus_in[7:0]   data-bus byte
//   flag_op[2:0]  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
//   carry_sel[1:0] ALU carry source: 0 C, 1 zero, 2 one, 3 zero
//   brk_push      B value placed in push_byte
//   instr_done    one-cycle pulse at the instruction boundary
//   carry_to_alu  ALU carry input
//   status_out    {N,V,1,0,D,I,Z,C}
//   push_byte     {N,V,1,brk_push,D,I,Z,C}
//   irq_mask      I as seen by interrupt polling
//   decimal       D flag
// -----------------------------------------------------------------------------
module status_register (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       update_nz,
  input  logic       update_c,
  input  logic       update_v,
  input  logic       bit_op,
  input  logic       load_bus,
  input  logic [7:0] bus_in,
  input  logic [2:0] flag_op,
  input  logic [1:0] carry_sel,
  input  logic       brk_push,
  input  logic       instr_done,
  output logic       carry_to_alu,
  output logic [7:0] status_out,
  output logic [7:0] push_byte,
  output logic       irq_mask,
  output logic       decimal
);

  localparam logic [2:0] FLAG_NONE = 3'd0;
  localparam logic [2:0] FLAG_CLC  = 3'd1;
  localparam logic [2:0] FLAG_SEC  = 3'd2;
  localparam logic [2:0] FLAG_CLI  = 3'd3;
  localparam logic [2:0] FLAG_SEI  = 3'd4;
  localparam logic [2:0] FLAG_CLV  = 3'd5;
  localparam logic [2:0] FLAG_CLD  = 3'd6;
  localparam logic [2:0] FLAG_SED  = 3'd7;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_nxt, v_nxt, d_nxt, i_nxt, z_nxt, c_nxt;
  logic irq_mask_q;

  // Next-state flags. Later assignments override earlier ones, so the order
  // below encodes the per-flag priority: update_* < bit_op < flag_op, with
  // load_bus overriding everything.
  always_comb begin
    n_nxt = n_q;
    v_nxt = v_q;
    d_nxt = d_q;
    i_nxt = i_q;
    z_nxt = z_q;
    c_nxt = c_q;

    if (load_bus) begin
      // bus_in[5:4] are the phantom 1 and B positions; neither is stored.
      n_nxt = bus_in[7];
      v_nxt = bus_in[6];
      d_nxt = bus_in[3];
      i_nxt = bus_in[2];
      z_nxt = bus_in[1];
      c_nxt = bus_in[0];
    end else begin
      if (update_nz) begin
        n_nxt = alu_n;
        z_nxt = alu_z;
      end
      if (update_c) begin
        c_nxt = alu_c;
      end
      if (update_v) begin
        v_nxt = alu_v;
      end

      if (bit_op) begin
        n_nxt = bus_in[7];
        v_nxt = bus_in[6];
        z_nxt = alu_z;
      end

      // Each flag_op touches exactly one flag; the others keep whatever the
      // ALU/BIT paths decided above.
      case (flag_op)
        FLAG_CLC: c_nxt = 1'b0;
        FLAG_SEC: c_nxt = 1'b1;
        FLAG_CLI: i_nxt = 1'b0;
        FLAG_SEI: i_nxt = 1'b1;
        FLAG_CLV: v_nxt = 1'b0;
        FLAG_CLD: d_nxt = 1'b0;
        FLAG_SED: d_nxt = 1'b1;
        FLAG_NONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_nxt;
      v_q <= v_nxt;
      d_q <= d_nxt;
      i_q <= i_nxt;
      z_q <= z_nxt;
      c_q <= c_nxt;
    end
  end

  // Sampling i_nxt rather than i_q means an instruction that changes I and
  // ends in the same cycle is already reflected after that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_mask_q <= 1'b1;
    end else if (instr_done) begin
      irq_mask_q <= i_nxt;
    end
  end

  always_comb begin
    carry_to_alu = 1'b0;
    case (carry_sel)
      2'd0:    carry_to_alu = c_q;
      2'd1:    carry_to_alu = 1'b0;
      2'd2:    carry_to_alu = 1'b1;
      default: carry_to_alu = 1'b0;
    endcase
  end

  assign status_out = {n_q, v_q, 1'b1, 1'b0,     d_q, i_q, z_q, c_q};
  assign push_byte  = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign irq_mask   = irq_mask_q;
  assign decimal    = d_q;

endmodule

// File: tb/tb_status_register.sv
module tb_status_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_n, alu_v, alu_z, alu_c;
  logic       update_nz, update_c, update_v;
  logic       bit_op, load_bus;
  logic [7:0] bus_in;
  logic [2:0] flag_op;
  logic [1:0] carry_sel;
  logic       brk_push, instr_done;
  logic       carry_to_alu;
  logic [7:0] status_out, push_byte;
  logic       irq_mask, decimal;

  int n_cmp  = 0;
  int n_fail = 0;

  status_register dut (
    .clk(clk), .rst(rst),
    .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
    .update_nz(update_nz), .update_c(update_c), .update_v(update_v),
    .bit_op(bit_op), .load_bus(load_bus), .bus_in(bus_in),
    .flag_op(flag_op), .carry_sel(carry_sel), .brk_push(brk_push),
    .instr_done(instr_done), .carry_to_alu(carry_to_alu),
    .status_out(status_out), .push_byte(push_byte),
    .irq_mask(irq_mask), .decimal(decimal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       load_bus;
    logic [7:0] bus_in;
    logic [2:0] flag_op;
    logic       bit_op;
    logic [2:0] upd;       // {update_nz, update_c, update_v}
    logic [3:0] alu_nvzc;  // {alu_n, alu_v, alu_z, alu_c}
    logic       instr_done;
    logic       brk_push;
    logic [1:0] carry_sel;
    logic [7:0] exp_status;
    logic       exp_irq;
    logic       exp_cta;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string nm, logic lb, logic [7:0] bi, logic [2:0] fo,
                              logic bo, logic [2:0] up, logic [3:0] alu, logic idn,
                              logic bp, logic [1:0] cs, logic [7:0] es, logic ei,
                              logic ec);
    vec_t v;
    v.name = nm; v.load_bus = lb; v.bus_in = bi; v.flag_op = fo; v.bit_op = bo;
    v.upd = up; v.alu_nvzc = alu; v.instr_done = idn; v.brk_push = bp;
    v.carry_sel = cs; v.exp_status = es; v.exp_irq = ei; v.exp_cta = ec;
    return v;
  endfunction

  task automatic check8(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    load_bus = 0; bus_in = 8'h00; flag_op = 3'd0; bit_op = 0;
    update_nz = 0; update_c = 0; update_v = 0;
    alu_n = 0; alu_v = 0; alu_z = 0; alu_c = 0;
    instr_done = 0; brk_push = 0; carry_sel = 2'd0;
  endtask

  // Drive one vector on the falling edge, queue its expectation, and compare
  // after the following rising edge.
  task automatic apply(vec_t v);
    vec_t e;
    logic [7:0] exp_push;
    @(negedge clk);
    load_bus = v.load_bus; bus_in = v.bus_in; flag_op = v.flag_op; bit_op = v.bit_op;
    {update_nz, update_c, update_v} = v.upd;
    {alu_n, alu_v, alu_z, alu_c} = v.alu_nvzc;
    instr_done = v.instr_done; brk_push = v.brk_push; carry_sel = v.carry_sel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    exp_push = {e.exp_status[7:5], e.brk_push, e.exp_status[3:0]};
    check8({e.name, ".status"}, status_out, e.exp_status);
    check8({e.name, ".push"}, push_byte, exp_push);
    check8({e.name, ".irq"}, {7'd0, irq_mask}, {7'd0, e.exp_irq});
    check8({e.name, ".cta"}, {7'd0, carry_to_alu}, {7'd0, e.exp_cta});
    check8({e.name, ".dec"}, {7'd0, decimal}, {7'd0, e.exp_status[3]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    rst = 1;
    #12;
    check8("reset.status", status_out, 8'h24);
    check8("reset.push", push_byte, 8'h24);
    check8("reset.irq", {7'd0, irq_mask}, 8'd1);
    @(negedge clk);
    rst = 0;

    //           name       lb bus    fo   bo upd     nvzc    id bp cs  status irq cta
    vecs.push_back(mk("idle0",  0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 0, 0, 2'd0, 8'h24, 1, 0));
    vecs.push_back(mk("idle2",  0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 0, 0, 2'd2, 8'h24, 1, 1));
    vecs.push_back(mk("ldFFb1", 1, 8'hFF, 3'd0, 0, 3'b000, 4'h0, 0, 1, 2'd0, 8'hEF, 1, 1));
    vecs.push_back(mk("holdb0", 0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 0, 0, 2'd0, 8'hEF, 1, 1));
    vecs.push_back(mk("ld00",   1, 8'h00, 3'd2, 1, 3'b111, 4'hF, 0, 0, 2'd0, 8'h20, 1, 0));
    vecs.push_back(mk("updclc", 0, 8'h00, 3'd1, 0, 3'b111, 4'hD, 0, 0, 2'd0, 8'hE0, 1, 0));
    vecs.push_back(mk("secnz",  0, 8'h00, 3'd2, 0, 3'b100, 4'h2, 0, 0, 2'd0, 8'h63, 1, 1));
    vecs.push_back(mk("bit80",  0, 8'h80, 3'd0, 1, 3'b101, 4'h4, 0, 0, 2'd0, 8'hA1, 1, 1));
    vecs.push_back(mk("bit40",  0, 8'h40, 3'd0, 1, 3'b100, 4'hA, 0, 0, 2'd0, 8'h63, 1, 1));
    vecs.push_back(mk("sed",    0, 8'h00, 3'd7, 0, 3'b000, 4'h0, 0, 0, 2'd1, 8'h6B, 1, 0));
    vecs.push_back(mk("cs3",    0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 0, 0, 2'd3, 8'h6B, 1, 0));
    vecs.push_back(mk("cldbit", 0, 8'hC0, 3'd6, 1, 3'b000, 4'h0, 0, 0, 2'd0, 8'hE1, 1, 1));
    vecs.push_back(mk("clvbit", 0, 8'h40, 3'd5, 1, 3'b000, 4'h2, 0, 0, 2'd0, 8'h23, 1, 1));
    vecs.push_back(mk("done0",  0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'h23, 0, 1));
    vecs.push_back(mk("seidn",  0, 8'h00, 3'd4, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'h27, 1, 1));
    vecs.push_back(mk("cli",    0, 8'h00, 3'd3, 0, 3'b000, 4'h0, 0, 0, 2'd0, 8'h23, 1, 1));
    vecs.push_back(mk("done1",  0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'h23, 0, 1));
    vecs.push_back(mk("updc0",  0, 8'h00, 3'd0, 0, 3'b010, 4'h0, 0, 0, 2'd0, 8'h22, 0, 0));
    vecs.push_back(mk("seidn2", 0, 8'h00, 3'd4, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'h26, 1, 0));
    vecs.push_back(mk("clidn",  0, 8'h00, 3'd3, 0, 3'b000, 4'h0, 1, 1, 2'd0, 8'h22, 0, 0));

    foreach (vecs[k]) apply(vecs[k]);

    // Interrupt-mask latency sequence starting from a fresh reset.
    do_reset();
    apply(mk("r_cli",   0, 8'h00, 3'd3, 0, 3'b000, 4'h0, 0, 0, 2'd0, 8'h20, 1, 0));
    apply(mk("r_done",  0, 8'h00, 3'd0, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'h20, 0, 0));
    apply(mk("r_seidn", 0, 8'h00, 3'd4, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'h24, 1, 0));

    // Asynchronous reset between edges while a load of 00 is pending.
    apply(mk("pre_ld",  1, 8'hFF, 3'd0, 0, 3'b000, 4'h0, 1, 0, 2'd0, 8'hEF, 1, 1));
    @(negedge clk);
    drive_idle();
    load_bus = 1; bus_in = 8'h00;
    #2;
    rst = 1;
    #1;
    check8("arst.status_now", status_out, 8'h24);
    check8("arst.irq_now", {7'd0, irq_mask}, 8'd1);
    @(posedge clk);
    #1;
    check8("arst.status_held", status_out, 8'h24);
    @(negedge clk);
    rst = 0;
    #1;
    check8("arst.status_rel", status_out, 8'h24);
    @(posedge clk);
    #1;
    check8("arst.first_edge", status_out, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
